// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-aware arbiter sharing one FIFO write port between NUM_REQ requesters.
// One IDLE cycle of arbitration precedes every grant; transfers happen only in BURST.
module fifo_wr_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DW           = 140,
  parameter int MAX_BURST    = 8,
  parameter int IDLE_TIMEOUT = 16,
  parameter int IDW          = $clog2(NUM_REQ)
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_last,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  fifo_full,
  output logic                  fifo_w_enable,
  output logic [DW-1:0]         data_to_fifo,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy,
  input  logic                  cnt_clr,
  output logic [15:0]           word_count
);

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  localparam logic [7:0]     BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [7:0]     IDLE_LAST  = 8'(IDLE_TIMEOUT - 1);
  localparam logic [IDW-1:0] LAST_IDX   = IDW'(NUM_REQ - 1);

  state_t         r_state, w_state_nxt;
  logic [IDW-1:0] r_grant, w_grant_nxt;
  logic [IDW-1:0] r_rr_ptr, w_rr_nxt;
  logic [IDW-1:0] w_pick;
  logic [7:0]     r_burst_cnt, w_burst_nxt;
  logic [7:0]     r_idle_cnt, w_idle_nxt;
  logic [15:0]    r_word_count;
  logic           w_any_valid;
  logic           w_xfer;
  logic           w_release;

  assign w_any_valid = |req_valid;

  // Scan downward so the requester closest to r_rr_ptr is the last to overwrite w_pick.
  always_comb begin
    w_pick = r_rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_pick = IDW'((int'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  // Handshake: a word moves when req_valid[g] & req_ready[g] are both high at a clk_in edge;
  // req_ready[g] is !fifo_full in BURST, so a write-enable pulse and an accept are the same event.
  always_comb begin
    req_ready    = '0;
    w_xfer       = 1'b0;
    data_to_fifo = '0;
    if (r_state == S_BURST) begin
      req_ready[r_grant] = !fifo_full;
      w_xfer             = req_valid[r_grant] & !fifo_full;
      data_to_fifo       = req_data[int'(r_grant)*DW +: DW];
    end
  end

  assign w_release = (r_state == S_BURST) &&
                     ((w_xfer && (req_last[r_grant] || (r_burst_cnt == BURST_LAST))) ||
                      ((r_idle_cnt == IDLE_LAST) && !req_valid[r_grant]));

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_ptr;
    w_burst_nxt = r_burst_cnt;
    w_idle_nxt  = r_idle_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_any_valid) begin
          w_state_nxt = S_BURST;
          w_grant_nxt = w_pick;
          w_burst_nxt = '0;
          w_idle_nxt  = '0;
        end
      end
      S_BURST: begin
        // A full FIFO freezes both counters.
        if (w_xfer) begin
          w_burst_nxt = r_burst_cnt + 8'd1;
          w_idle_nxt  = '0;
        end else if (!req_valid[r_grant] && !fifo_full) begin
          w_idle_nxt = r_idle_cnt + 8'd1;
        end
        if (w_release) begin
          w_state_nxt = S_IDLE;
          w_rr_nxt    = (r_grant == LAST_IDX) ? '0 : r_grant + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_idle_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_idle_cnt  <= w_idle_nxt;
    end
  end

  // Clear beats a same-cycle write; the count wraps naturally at 16 bits.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_word_count <= '0;
    end else if (cnt_clr) begin
      r_word_count <= '0;
    end else if (w_xfer) begin
      r_word_count <= r_word_count + 16'd1;
    end
  end

  assign fifo_w_enable = w_xfer;
  assign busy          = (r_state == S_BURST);
  assign grant_id      = r_grant;
  assign word_count    = r_word_count;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-requester source queues feed the DUT and a
// scoreboard of {grant_id, data} words checks every FIFO write in the expected order.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int DW           = 140;
  localparam int MAX_BURST    = 8;
  localparam int IDLE_TIMEOUT = 16;
  localparam int IDW          = 2;
  localparam int W            = IDW + DW;
  localparam int CW           = 160;

  logic                  clk_in = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_last;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  fifo_full;
  logic                  fifo_w_enable;
  logic [DW-1:0]         data_to_fifo;
  logic [IDW-1:0]        grant_id;
  logic                  busy;
  logic                  cnt_clr;
  logic [15:0]           word_count;

  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .DW(DW), .MAX_BURST(MAX_BURST),
    .IDLE_TIMEOUT(IDLE_TIMEOUT), .IDW(IDW)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_w_enable(fifo_w_enable), .data_to_fifo(data_to_fifo),
    .grant_id(grant_id), .busy(busy),
    .cnt_clr(cnt_clr), .word_count(word_count)
  );

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- bench state ----------------
  int n_vec = 0;
  int n_err = 0;
  int n_wr  = 0;
  int cyc   = 0;
  int base  = 0;
  logic [W-1:0]  exp_q[$];
  logic [DW:0]   src_q[NUM_REQ][$];
  logic [DW-1:0] pend_q[NUM_REQ][$];
  int            wr_cyc_q[$];
  logic [NUM_REQ-1:0] fire = '0;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  function automatic void drive_srcs();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_q[i].size() > 0) begin
        req_valid[i]            = 1'b1;
        req_last[i]             = src_q[i][0][DW];
        req_data[i*DW +: DW]    = src_q[i][0][DW-1:0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  endfunction

  function automatic bit srcs_empty();
    bit e = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  task automatic push_pkt(input int id, input int n, input bit last_at_end);
    logic [DW-1:0] w;
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < DW; b++) w[b] = 1'($urandom_range(0, 1));
      src_q[id].push_back({(last_at_end && (k == n - 1)), w});
      pend_q[id].push_back(w);
    end
    drive_srcs();
  endtask

  task automatic expect_words(input int id, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({IDW'(id), pend_q[id].pop_front()});
  endtask

  task automatic wait_done(input string tag, input int budget);
    int t = 0;
    while ((exp_q.size() != 0 || busy || !srcs_empty()) && t < budget) begin
      step();
      t++;
    end
    chk(tag, CW'(t < budget), CW'(1));
  endtask

  task automatic wait_writes(input string tag, input int target, input int budget);
    int t = 0;
    while (n_wr < target && t < budget) begin
      step();
      t++;
    end
    chk(tag, CW'(n_wr >= target), CW'(1));
  endtask

  // Source queues advance right after the edge that accepted their head word.
  always @(posedge clk_in) begin
    cyc++;
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    drive_srcs();
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk_in) begin
    fire = req_valid & req_ready;
    if (rst_n && fifo_w_enable) begin
      n_wr++;
      wr_cyc_q.push_back(cyc);
      if (exp_q.size() != 0) begin
        chk("fifo_write", CW'({grant_id, data_to_fifo}), CW'(exp_q.pop_front()));
      end else begin
        n_vec++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_write: got id %0d data %0h want no write", grant_id, data_to_fifo);
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    cnt_clr   = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    #1;
    chk("rst_we",    CW'(fifo_w_enable), CW'(0));
    chk("rst_ready", CW'(req_ready),     CW'(0));
    chk("rst_data",  CW'(data_to_fifo),  CW'(0));
    chk("rst_busy",  CW'(busy),          CW'(0));
    chk("rst_grant", CW'(grant_id),      CW'(0));
    chk("rst_count", CW'(word_count),    CW'(0));
    step();
    step();
    rst_n = 1'b1;
    step();

    // Single requester, 3-word packet.
    push_pkt(0, 3, 1'b1);
    expect_words(0, 3);
    step();
    chk("t1_busy",  CW'(busy),          CW'(1));
    chk("t1_grant", CW'(grant_id),      CW'(0));
    chk("t1_we0",   CW'(fifo_w_enable), CW'(1));
    step();
    chk("t1_we1",   CW'(fifo_w_enable), CW'(1));
    step();
    chk("t1_we2",   CW'(fifo_w_enable), CW'(1));
    step();
    chk("t1_idle",  CW'(busy),          CW'(0));
    chk("t1_we_off", CW'(fifo_w_enable), CW'(0));
    chk("t1_count", CW'(word_count),    CW'(3));

    // Round robin starting from rr_ptr=1: reqs 1, 3, then 0 twice.
    base = n_wr;
    wr_cyc_q.delete();
    push_pkt(0, 1, 1'b1);
    push_pkt(0, 1, 1'b1);
    push_pkt(1, 1, 1'b1);
    push_pkt(3, 1, 1'b1);
    expect_words(1, 1);
    expect_words(3, 1);
    expect_words(0, 2);
    wait_done("t2_done", 60);
    chk("t2_nwr", CW'(n_wr - base), CW'(4));
    if (wr_cyc_q.size() == 4) begin
      for (int k = 1; k < 4; k++) chk("t2_gap", CW'(wr_cyc_q[k] - wr_cyc_q[k-1]), CW'(2));
    end

    // Burst limit: req 2 streams 20 words, req 1 joins after req 2 is granted.
    base = n_wr;
    wr_cyc_q.delete();
    push_pkt(2, 20, 1'b1);
    step();
    push_pkt(1, 1, 1'b1);
    expect_words(2, 8);
    expect_words(1, 1);
    expect_words(2, 12);
    wait_done("t3_done", 200);
    chk("t3_nwr", CW'(n_wr - base), CW'(21));
    if (wr_cyc_q.size() == 21) begin
      chk("t3_burst_span", CW'(wr_cyc_q[7] - wr_cyc_q[0]), CW'(7));
      chk("t3_gap_r1",     CW'(wr_cyc_q[8] - wr_cyc_q[7]), CW'(2));
      chk("t3_gap_r2",     CW'(wr_cyc_q[9] - wr_cyc_q[8]), CW'(2));
      chk("t3_gap_limit",  CW'(wr_cyc_q[17] - wr_cyc_q[16]), CW'(2));
    end

    // Backpressure: 5 full cycles after 2 words of an 8-word packet.
    base = n_wr;
    wr_cyc_q.delete();
    push_pkt(0, 8, 1'b1);
    expect_words(0, 8);
    wait_writes("t4_first", base + 2, 20);
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4_we_full",    CW'(fifo_w_enable), CW'(0));
      chk("t4_ready_full", CW'(req_ready),     CW'(0));
      chk("t4_busy_full",  CW'(busy),          CW'(1));
      step();
    end
    fifo_full = 1'b0;
    wait_done("t4_done", 60);
    chk("t4_nwr", CW'(n_wr - base), CW'(8));
    if (wr_cyc_q.size() == 8) chk("t4_span", CW'(wr_cyc_q[7] - wr_cyc_q[0]), CW'(12));

    // Idle timeout: req 1 stops after 2 words, req 3 waits.
    base = n_wr;
    wr_cyc_q.delete();
    push_pkt(1, 2, 1'b0);
    push_pkt(3, 1, 1'b1);
    expect_words(1, 2);
    expect_words(3, 1);
    wait_done("t5_done", 100);
    chk("t5_nwr", CW'(n_wr - base), CW'(3));
    if (wr_cyc_q.size() == 3) chk("t5_timeout", CW'(wr_cyc_q[2] - wr_cyc_q[1]), CW'(18));

    // Idle timeout frozen by a full FIFO for 30 cycles.
    base = n_wr;
    wr_cyc_q.delete();
    push_pkt(0, 2, 1'b0);
    push_pkt(2, 1, 1'b1);
    expect_words(0, 2);
    expect_words(2, 1);
    wait_writes("t5b_first", base + 2, 20);
    fifo_full = 1'b1;
    repeat (30) step();
    chk("t5b_busy",  CW'(busy),     CW'(1));
    chk("t5b_grant", CW'(grant_id), CW'(0));
    fifo_full = 1'b0;
    wait_done("t5b_done", 100);
    chk("t5b_nwr", CW'(n_wr - base), CW'(3));
    if (wr_cyc_q.size() == 3) chk("t5b_timeout", CW'(wr_cyc_q[2] - wr_cyc_q[1]), CW'(48));

    // Counter clear, alone and together with a write.
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("t6_clr", CW'(word_count), CW'(0));
    base = n_wr;
    push_pkt(3, 3, 1'b1);
    expect_words(3, 3);
    wait_writes("t6_first", base + 1, 20);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("t6_xfer_same_cycle", CW'(n_wr - base), CW'(2));
    chk("t6_clr_wins",        CW'(word_count),  CW'(0));
    wait_done("t6_done", 40);
    chk("t6_after", CW'(word_count), CW'(1));

    // Reset mid-burst, then arbitration restarts from req 0.
    base = n_wr;
    push_pkt(2, 6, 1'b1);
    expect_words(2, 6);
    wait_writes("t7_first", base + 2, 20);
    rst_n = 1'b0;
    #1;
    chk("t7_we",    CW'(fifo_w_enable), CW'(0));
    chk("t7_ready", CW'(req_ready),     CW'(0));
    chk("t7_data",  CW'(data_to_fifo),  CW'(0));
    chk("t7_busy",  CW'(busy),          CW'(0));
    chk("t7_grant", CW'(grant_id),      CW'(0));
    chk("t7_count", CW'(word_count),    CW'(0));
    src_q[2].delete();
    pend_q[2].delete();
    exp_q.delete();
    drive_srcs();
    step();
    step();
    rst_n = 1'b1;
    step();
    base = n_wr;
    wr_cyc_q.delete();
    push_pkt(0, 1, 1'b1);
    push_pkt(0, 1, 1'b1);
    push_pkt(1, 1, 1'b1);
    push_pkt(3, 1, 1'b1);
    expect_words(0, 1);
    expect_words(1, 1);
    expect_words(3, 1);
    expect_words(0, 1);
    wait_done("t7_done", 60);
    chk("t7_nwr",       CW'(n_wr - base), CW'(4));
    chk("t7_count_end", CW'(word_count),  CW'(4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin, burst-aware arbiter that shares the write port of the 8-deep x 140-bit clock-domain-crossing FIFO between NUM_REQ requesters in the clk_in (write) domain.
- Grants one requester at a time and drives the FIFO write enable and write data combinationally, honouring fifo_full.
- Releases the grant on end-of-packet, on burst limit, or on requester idle timeout.
- Keeps a running count of accepted words for software/debug.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DW, 140, data width, matches the FIFO word
MAX_BURST, 8, max words per grant before forced rotation (1..255)
IDLE_TIMEOUT, 16, consecutive cycles of granted requester's valid low before grant release (1..255)
IDW, $clog2(NUM_REQ), grant index width

Ports:
clk_in  in  1  write-domain clock
rst_n  in  1  asynchronous reset, active-low
req_valid  in  NUM_REQ  per-requester word valid
req_last  in  NUM_REQ  per-requester last word of packet, qualified by req_valid
req_data  in  NUM_REQ*DW  requester i word at bits [i*DW +: DW]
req_ready  out  NUM_REQ  per-requester word accepted this cycle when ready&valid
fifo_full  in  1  FIFO full flag (write domain)
fifo_w_enable  out  1  FIFO write enable
data_to_fifo  out  DW  FIFO write data
grant_id  out  IDW  index of current grantee
busy  out  1  1 while in state BURST
cnt_clr  in  1  synchronous clear of word_count
word_count  out  16  total words written to FIFO, wraps at 2^16

Behaviour:
- Reset (rst_n low, async): state=IDLE, grant_id=0, rr_ptr=0, burst_cnt=0, idle_cnt=0, word_count=0. Outputs: fifo_w_enable=0, req_ready=0, data_to_fifo=0, busy=0.
- States: IDLE, BURST.
- IDLE:
  - If any req_valid: choose the first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Register grant_id=i, clear burst_cnt and idle_cnt, go to BURST next cycle.
  - No transfer occurs in IDLE (1-cycle arbitration bubble).
  - If no req_valid: stay in IDLE.
- BURST, with g=grant_id; all signals below are combinational:
  - req_ready[g] = !fifo_full; all other req_ready = 0.
  - xfer = req_valid[g] & !fifo_full.
  - fifo_w_enable = xfer.
  - data_to_fifo = req_data slice g (=0 outside BURST).
  - On xfer: burst_cnt+1, idle_cnt cleared, word_count+1.
  - fifo_full high: no xfer; burst_cnt and idle_cnt hold. A full FIFO never causes release.
  - req_valid[g] low and fifo_full low: idle_cnt+1.
  - Release, to IDLE next cycle with rr_ptr = (g+1) mod NUM_REQ, when any of:
    - xfer & req_last[g]
    - xfer & burst_cnt==MAX_BURST-1
    - idle_cnt==IDLE_TIMEOUT-1 & !req_valid[g]
- Requesters must hold req_data/req_last stable while req_valid is high and not ready. The arbiter does not check this.
- Non-granted requesters are never accepted. Their valid may toggle freely.
- cnt_clr: word_count=0 next cycle. If xfer occurs the same cycle, clr wins and the result is 0.
- word_count wraps from 0xFFFF to 0x0000.
- Reset mid-burst: immediate return to IDLE/reset values. A partial packet already written stays in the FIFO; flushing it is the system's responsibility.
- Max throughput: MAX_BURST words per MAX_BURST+1 cycles under continuous requests.

Test Plan:
- Single requester: req 0 sends a 3-word packet (D0,D1,D2, last on D2), fifo_full=0 -> grant_id=0 one cycle after valid; fifo_w_enable high 3 consecutive cycles with D0..D2; busy drops; word_count=3; rr_ptr=1.
- Round-robin: reqs 0,1,3 all valid, each with 1-word packets -> write order is req 0, req 1, req 3, req 0, each grant separated by one IDLE cycle.
- Burst limit, MAX_BURST=8: req 2 streams 20 words without last while req 1 is valid -> exactly 8 writes from req 2, then req 1 granted. Req 2 resumes only after req 1 releases.
- Backpressure: fifo_full forced high for 5 cycles mid-packet -> fifo_w_enable=0 and req_ready=0 during those cycles; burst_cnt and idle_cnt frozen; no word lost or duplicated once full drops.
- Idle timeout, IDLE_TIMEOUT=16: grantee drops valid after 2 words with no last -> grant released after exactly 16 idle cycles. Next requester granted. Re-extending the test with fifo_full high during the idle period shows no release.
- Counter/reset: cnt_clr and xfer in the same cycle -> word_count=0. Assert rst_n low mid-burst -> all outputs 0 asynchronously; state returns to IDLE; arbitration restarts from req 0.
